// File: rtl/seven_seg_scanner.sv
// Time-multiplexed driver for an eight-digit seven-segment display.
// Scans one digit per slot and latches a new frame only at the frame boundary.
module seven_seg_scanner #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] display_data,
    input  logic        blank_all,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t CNT_MAX = cnt_t'(REFRESH_DIV - 1);

    cnt_t        cnt;
    cnt_t        cnt_d;
    logic [2:0]  idx;
    logic [2:0]  idx_d;
    logic [31:0] frame_q;
    logic [31:0] frame_d;
    logic        wrap;
    logic        snap;
    logic        dark;
    logic [3:0]  code;
    logic [7:0]  an_d;
    logic [6:0]  seg_d;

    function automatic logic [6:0] decode(input logic [3:0] c);
        logic [6:0] s;
        s = 7'h7F;
        unique case (c)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h7F;
        endcase
        return s;
    endfunction

    // Snapshot only at the last cycle of slot 7 so a frame never tears.
    always_comb begin
        wrap    = (cnt == CNT_MAX);
        snap    = wrap && (idx == 3'd7);
        cnt_d   = wrap ? '0 : cnt + 1'b1;
        idx_d   = wrap ? idx + 3'd1 : idx;
        frame_d = snap ? display_data : frame_q;
    end

    always_comb begin
        dark  = blank_all || (int'(cnt) < BLANK_CYCLES);
        code  = frame_q[{idx, 2'b00} +: 4];
        an_d  = 8'hFF;
        seg_d = 7'h7F;
        if (!dark) begin
            an_d  = ~(8'h01 << idx);
            seg_d = decode(code);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            idx        <= 3'd0;
            frame_q    <= 32'hFFFF_FFFF;
            an         <= 8'hFF;
            seg        <= 7'h7F;
            frame_done <= 1'b0;
        end else begin
            cnt        <= cnt_d;
            idx        <= idx_d;
            frame_q    <= frame_d;
            an         <= an_d;
            seg        <= seg_d;
            frame_done <= snap;
        end
    end

    assign dp = 1'b1;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with REFRESH_DIV=8, BLANK_CYCLES=2.
// Expected values are hand-derived from the cycle count since reset release.
module tb_seven_seg_scanner;

    localparam int RD = 8;
    localparam int BK = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] display_data = 32'hFFFF_FFFF;
    logic        blank_all = 1'b0;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int checks = 0;
    int errors = 0;
    int t = 0;
    int mt = 0;
    bit mon_en = 1'b0;

    seven_seg_scanner #(
        .REFRESH_DIV (RD),
        .BLANK_CYCLES(BK)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .display_data(display_data),
        .blank_all   (blank_all),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0d got %h exp %h", tag, t, got, exp);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
        t += n;
    endtask

    task automatic goto(input int n);
        if (n > t) adv(n - t);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        t = 0;
    endtask

    task automatic chk_out(input string tag, input logic [7:0] ea,
                           input logic [6:0] es);
        chk({tag, "_an"}, {24'h0, an}, {24'h0, ea});
        chk({tag, "_seg"}, {25'h0, seg}, {25'h0, es});
    endtask

    // Per-cycle invariants: one anode at most, dp off, dead time respected.
    always @(posedge clk) begin
        automatic logic rs = reset;
        automatic int   prev;
        #1;
        prev = mt;
        if (rs) mt = 0;
        else mt = mt + 1;
        if (mon_en) begin
            chk("onehot", {31'h0, $onehot0(~an)}, 32'd1);
            chk("dp", {31'h0, dp}, 32'd1);
            if (an != 8'hFF)
                chk("dead", {31'h0, (!rs && (prev % RD) >= BK)}, 32'd1);
        end
    end

    initial begin
        // Reset values and the blank first frame.
        display_data = 32'hFFFF_FF00;
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_out("rst", 8'hFF, 7'h7F);
        chk("rst_fd", {31'h0, frame_done}, 32'd0);
        chk("rst_dp", {31'h0, dp}, 32'd1);
        reset = 1'b0;
        t = 0;
        mon_en = 1'b1;
        goto(1);
        chk_out("t1_e1", 8'hFF, 7'h7F);
        goto(11);
        chk_out("t1_f0s1", 8'hFD, 7'h7F);
        goto(63);
        chk("t1_fd63", {31'h0, frame_done}, 32'd0);
        goto(64);
        chk("t1_fd64", {31'h0, frame_done}, 32'd1);
        goto(65);
        chk("t1_fd65", {31'h0, frame_done}, 32'd0);
        goto(66);
        chk_out("t1_dead", 8'hFF, 7'h7F);
        goto(67);
        chk_out("t1_s0", 8'hFE, 7'h40);
        goto(75);
        chk_out("t1_s1", 8'hFD, 7'h40);
        goto(83);
        chk_out("t1_s2", 8'hFB, 7'h7F);
        goto(128);
        chk_out("t1_s7", 8'h7F, 7'h7F);
        chk("t1_fd128", {31'h0, frame_done}, 32'd1);

        // Mixed digits and periodic frame_done.
        display_data = 32'hCDFF_FF05;
        do_reset();
        goto(67);
        chk_out("t2_s0", 8'hFE, 7'h12);
        goto(115);
        chk_out("t2_s6", 8'hBF, 7'h21);
        goto(123);
        chk_out("t2_s7", 8'h7F, 7'h46);
        goto(128);
        chk("t2_fd128", {31'h0, frame_done}, 32'd1);
        goto(129);
        chk("t2_fd129", {31'h0, frame_done}, 32'd0);
        goto(192);
        chk("t2_fd192", {31'h0, frame_done}, 32'd1);

        // Mid-frame data change must wait for the next snapshot.
        display_data = 32'hFFFF_FF12;
        do_reset();
        goto(66);
        display_data = 32'hFFFF_FF34;
        goto(67);
        chk_out("t3_old0", 8'hFE, 7'h24);
        goto(75);
        chk_out("t3_old1", 8'hFD, 7'h79);
        goto(128);
        chk("t3_fd128", {31'h0, frame_done}, 32'd1);
        goto(131);
        chk_out("t3_new0", 8'hFE, 7'h19);
        goto(139);
        chk_out("t3_new1", 8'hFD, 7'h30);

        // blank_all for 20 cycles across a frame boundary.
        display_data = 32'hCDFF_FF05;
        do_reset();
        goto(115);
        chk_out("t4_pre", 8'hBF, 7'h21);
        blank_all = 1'b1;
        goto(116);
        chk_out("t4_on", 8'hFF, 7'h7F);
        goto(125);
        chk_out("t4_mid", 8'hFF, 7'h7F);
        goto(128);
        chk("t4_fd128", {31'h0, frame_done}, 32'd1);
        goto(135);
        chk_out("t4_last", 8'hFF, 7'h7F);
        blank_all = 1'b0;
        goto(136);
        chk_out("t4_off", 8'hFE, 7'h12);

        // Reset coinciding with the snapshot edge aborts the frame.
        display_data = 32'hCDFF_FF05;
        do_reset();
        goto(63);
        chk("t5_fd63", {31'h0, frame_done}, 32'd0);
        reset = 1'b1;
        goto(64);
        chk("t5_fd64", {31'h0, frame_done}, 32'd0);
        chk_out("t5_rst", 8'hFF, 7'h7F);
        goto(65);
        chk("t5_fd65", {31'h0, frame_done}, 32'd0);
        reset = 1'b0;
        t = 0;
        goto(3);
        chk_out("t5_restart", 8'hFE, 7'h7F);
        goto(64);
        chk("t5_fd_new", {31'h0, frame_done}, 32'd1);
        goto(67);
        chk_out("t5_shown", 8'hFE, 7'h12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seven_seg_scanner.md
SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, clock cycles per digit slot (legal range >= 2).
REQ-002 Parameter BLANK_CYCLES, default 16, anode-off dead time at the start of each slot (legal range 0 to REFRESH_DIV-1).
REQ-003 Port clk  input  1  system clock; all logic updates on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port display_data  input  32  eight 4-bit codes; [31:28] = digit 7 (AN7) ... [3:0] = digit 0 (AN0).
REQ-006 Port blank_all  input  1  when high, forces every digit off.
REQ-007 Port an  output  8  anode enables, active-low, registered.
REQ-008 Port seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-009 Port dp  output  1  decimal point, active-low; held constant 1 (off).
REQ-010 Port frame_done  output  1  one-cycle pulse when a new display_data snapshot is latched.

Function
REQ-011 A prescaler cnt SHALL count 0..REFRESH_DIV-1 and wrap to 0; a 3-bit digit index idx SHALL increment (7 wraps to 0) on the cycle where cnt wraps.
REQ-012 On the edge where cnt==REFRESH_DIV-1 and idx==7, frame_q SHALL load display_data; display_data SHALL be ignored at all other times (no mid-frame tearing).
REQ-013 frame_done SHALL be 1 for exactly the single cycle after each frame_q load, and 0 otherwise.
REQ-014 Each cycle, an SHALL register 8'hFF if blank_all==1 or cnt<BLANK_CYCLES; otherwise it SHALL register all ones except bit idx at 0.
REQ-015 Each cycle, seg SHALL register 7'h7F whenever an would register 8'hFF; otherwise it SHALL register decode(frame_q[4*idx+3:4*idx]).
REQ-016 The decode table (hex, active-low) SHALL be: 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 B:03 C:46 D:21 E:06 F:7F; code F means blank.
REQ-017 an and seg SHALL lag the cnt/idx state they are derived from by exactly one clock.
REQ-018 At most one an bit SHALL ever be 0 in any cycle.
REQ-019 blank_all SHALL NOT stall cnt, idx or the frame_q snapshot; its effect on an/seg SHALL appear one cycle after assertion or deassertion.
REQ-020 Full frame period SHALL be 8*REFRESH_DIV cycles; with BLANK_CYCLES==0, digits SHALL be driven back-to-back with no dead time.

Reset
REQ-021 While reset==1 at a clock edge: cnt=0, idx=0, frame_q=32'hFFFFFFFF, an=8'hFF, seg=7'h7F, dp=1, frame_done=0.
REQ-022 Reset SHALL take priority over all other activity, including a coincident snapshot; asserting reset mid-frame SHALL abort the frame with no frame_done pulse.
REQ-023 The first frame after reset SHALL display all-blank segments (frame_q reset value); the first snapshot SHALL occur 8*REFRESH_DIV cycles after reset release.

Verification (REFRESH_DIV=8, BLANK_CYCLES=2)
REQ-024 Reset, then display_data=32'hFFFFFF00 held -> first 64 cycles seg=7F; in second frame, slot 0 after 2 dead cycles: an=FE, seg=40; slot 1: an=FD, seg=40; slots 2-7: an cycles FB..7F with seg=7F.
REQ-025 display_data=32'hCDFFFF05 -> after a snapshot: slot 7 an=7F seg=46; slot 6 an=BF seg=21; slot 0 an=FE seg=12; frame_done pulses every 64 cycles.
REQ-026 Change display_data from 32'hFFFFFF12 to 32'hFFFFFF34 in mid-frame -> the remaining slots of the current frame still show 1/2; the next frame shows 3/4.
REQ-027 Assert blank_all for 20 cycles mid-slot -> an=FF and seg=7F, both one cycle delayed; idx progression and frame_done timing unchanged.
REQ-028 Assert reset one cycle before the frame's final cnt wrap -> no frame_done, an=FF, seg=7F, frame_q=FFFFFFFF; scan restarts at idx 0.
REQ-029 All cycles of all tests -> never more than one an bit low, dp always 1, and every low-an cycle preceded by the BLANK_CYCLES dead time within its slot.
